// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: buffers PHY RX bytes in a FIFO and replays them (echo or fixed reply) paced by tx_busy; optional macro UART_ECHO_UPCASE_EN
module uart_echo_ctrl #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter logic [DW-1:0] REPLY_BYTE = DW'(8'h77),
  parameter int BUSY_TO = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_received,
  input  logic [DW-1:0]           rx_byte,
  input  logic                    rx_error,
  input  logic                    tx_busy,
  input  logic                    mode,
  input  logic                    clr_flags,
  output logic                    tx_transmit,
  output logic [DW-1:0]           tx_byte,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic                    tx_fault
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DW-1:0] tx_byte_q, tx_byte_d, wr_byte;
  logic [DW-1:0] mem_q [DEPTH];
  logic tx_transmit_q, tx_transmit_d, overflow_q, overflow_d, tx_fault_q, tx_fault_d;
  logic pop, push, valid_rx, fault_evt;
  assign fifo_level = wptr_q - rptr_q;
  assign tx_transmit = tx_transmit_q;
  assign tx_byte = tx_byte_q;
  assign overflow = overflow_q;
  assign tx_fault = tx_fault_q;
  // byte stored on push: fixed reply or (optionally upper-cased) echo
  always_comb begin
    wr_byte = mode ? REPLY_BYTE : rx_byte;
`ifdef UART_ECHO_UPCASE_EN
    if (DW == 8 && !mode && rx_byte >= DW'(8'h61) && rx_byte <= DW'(8'h7A)) wr_byte = rx_byte - DW'(8'h20);
`endif
  end
  // FIFO accounting, replay FSM and sticky flags
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tx_byte_d = tx_byte_q;
    fault_evt = 1'b0;
    pop = state_q == IDLE && fifo_level != '0;
    valid_rx = rx_received && !rx_error;
    push = valid_rx && (fifo_level < (AW+1)'(DEPTH) || pop);
    tx_transmit_d = pop;
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
    case (state_q)
      IDLE: if (pop) begin
        state_d = WAIT_BUSY;
        tx_byte_d = mem_q[rptr_q[AW-1:0]];
        cnt_d = '0;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
        else if (cnt_q == 4'(BUSY_TO - 1)) begin
          fault_evt = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 4'd1;
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
    overflow_d = (overflow_q && !clr_flags) || (valid_rx && !push);
    tx_fault_d = (tx_fault_q && !clr_flags) || fault_evt;
  end
  // control registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      tx_byte_q <= '0;
      tx_transmit_q <= 1'b0;
      overflow_q <= 1'b0;
      tx_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      tx_byte_q <= tx_byte_d;
      tx_transmit_q <= tx_transmit_d;
      overflow_q <= overflow_d;
      tx_fault_q <= tx_fault_d;
    end
  end
  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_byte;
  end
endmodule
